// File: rtl/byte_printer_arbiter.sv
// byte_printer_arbiter
//   Shares one byte-wide printer sink among N_REQ byte-stream requesters.
//   A round-robin winner holds the sink until it sends a newline, reaches
//   MAX_BURST data bytes, or stays idle for IDLE_TIMEOUT cycles. When
//   TAG_EN is set, an ASCII source tag ('0' + index) precedes each grant's
//   data.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous, active-low reset
//   req_valid  : [N_REQ]   per-requester byte valid
//   req_byte   : [8*N_REQ] per-requester byte, requester i at [8i+7:8i]
//   req_ready  : [N_REQ]   per-requester accept, one-hot or zero
//   out_valid  : byte valid to the sink
//   out_byte   : byte to the sink
//   out_ready  : sink accept
//   out_src    : granted requester index, 0 whenever out_valid is 0
module byte_printer_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 16,
  parameter int TAG_EN       = 1,
  localparam int SRC_W       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_byte,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_byte,
  input  logic                 out_ready,
  output logic [SRC_W-1:0]     out_src
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [7:0]       NEWLINE    = 8'h0A;
  localparam logic [7:0]       TAG_BASE   = 8'h30;
  localparam logic [7:0]       BURST_LIM  = 8'(MAX_BURST);
  localparam logic [7:0]       STALL_LIM  = 8'(IDLE_TIMEOUT);
  localparam logic [SRC_W:0]   N_REQ_W    = (SRC_W+1)'(N_REQ);
  localparam logic [SRC_W-1:0] LAST_RESET = SRC_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [7:0]       stall_cnt_q, stall_cnt_d;

  // Unpack the flat byte bus so the granted byte is a simple array read.
  logic [7:0] byte_arr [N_REQ];
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign byte_arr[gi] = req_byte[8*gi +: 8];
    end
  endgenerate

  // Round-robin search starting just above last_grant. The sum never
  // exceeds 2*N_REQ-1, so one conditional subtract performs the wrap.
  logic             any_req;
  logic [SRC_W-1:0] winner;
  logic [SRC_W:0]   probe_wide;
  logic [SRC_W-1:0] probe;

  always_comb begin
    any_req    = 1'b0;
    winner     = '0;
    probe_wide = '0;
    probe      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      probe_wide = {1'b0, last_grant_q} + (SRC_W+1)'(k);
      if (probe_wide >= N_REQ_W) begin
        probe_wide = probe_wide - N_REQ_W;
      end
      probe = probe_wide[SRC_W-1:0];
      if (!any_req && req_valid[probe]) begin
        any_req = 1'b1;
        winner  = probe;
      end
    end
  end

  // Saturating increments; both counters are 8 bits and must never wrap.
  logic [7:0] burst_inc;
  logic [7:0] stall_inc;
  assign burst_inc = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
  assign stall_inc = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;

  logic       grant_valid;
  logic [7:0] grant_byte;
  assign grant_valid = req_valid[grant_q];
  assign grant_byte  = byte_arr[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    out_valid    = 1'b0;
    out_byte     = 8'h00;
    out_src      = '0;
    req_ready    = '0;

    unique case (state_q)
      ST_IDLE: begin
        burst_cnt_d = 8'd0;
        stall_cnt_d = 8'd0;
        if (any_req) begin
          grant_d = winner;
          state_d = (TAG_EN != 0) ? ST_TAG : ST_DATA;
        end
      end

      ST_TAG: begin
        out_valid = 1'b1;
        out_byte  = TAG_BASE + 8'(grant_q);
        out_src   = grant_q;
        if (out_ready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        // Straight combinational pass-through of the granted requester.
        out_valid          = grant_valid;
        out_byte           = grant_byte;
        out_src            = grant_valid ? grant_q : '0;
        req_ready[grant_q] = out_ready;

        if (grant_valid && out_ready) begin
          burst_cnt_d = burst_inc;
          stall_cnt_d = 8'd0;
          // Newline and burst limit on the same byte still give one release.
          if (grant_byte == NEWLINE || burst_inc >= BURST_LIM) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            burst_cnt_d  = 8'd0;
          end
        end else if (!grant_valid) begin
          stall_cnt_d = stall_inc;
          if (stall_inc >= STALL_LIM) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            burst_cnt_d  = 8'd0;
            stall_cnt_d  = 8'd0;
          end
        end
        // Valid but not ready: sink backpressure, stall count is held.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RESET;
      burst_cnt_q  <= 8'd0;
      stall_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_byte_printer_arbiter.sv
// Directed testbench for byte_printer_arbiter with default parameters
// (4 requesters, MAX_BURST 64, IDLE_TIMEOUT 16, tags enabled).
module tb_byte_printer_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_byte;
  logic           out_ready;
  logic [1:0]     out_src;

  int checks;
  int errors;
  int xfer_cnt [N];

  byte_printer_arbiter #(
    .N_REQ(N),
    .MAX_BURST(64),
    .IDLE_TIMEOUT(16),
    .TAG_EN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_byte(req_byte),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_byte(out_byte),
    .out_ready(out_ready),
    .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs are changed only after this point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_byte[8*i +: 8] = b;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    for (int i = 0; i < N; i++) xfer_cnt[i] = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_byte  = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte",  32'(out_byte),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Two requesters, "A\n" each; requester 0 first, then one bubble, then 2.
    tick();
    reset     = 1'b1;
    req_valid = 4'b0101;
    set_byte(0, 8'h41);
    set_byte(2, 8'h41);
    out_ready = 1'b1;
    tick();
    chk("a_tag0_valid", 32'(out_valid), 32'd1);
    chk("a_tag0_byte",  32'(out_byte),  32'h30);
    chk("a_tag0_src",   32'(out_src),   32'd0);
    chk("a_tag0_ready", 32'(req_ready), 32'd0);
    tick();
    chk("a_data0_byte",  32'(out_byte),  32'h41);
    chk("a_data0_ready", 32'(req_ready), 32'b0001);
    tick();
    set_byte(0, 8'h0A);
    settle();
    chk("a_nl0_byte", 32'(out_byte), 32'h0A);
    tick();
    req_valid[0] = 1'b0;
    settle();
    chk("a_bubble_valid", 32'(out_valid), 32'd0);
    chk("a_bubble_ready", 32'(req_ready), 32'd0);
    tick();
    chk("a_tag2_byte", 32'(out_byte), 32'h32);
    chk("a_tag2_src",  32'(out_src),  32'd2);
    tick();
    set_byte(2, 8'h0A);
    settle();
    chk("a_nl2_byte",  32'(out_byte),  32'h0A);
    chk("a_nl2_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    settle();
    chk("a_end_valid", 32'(out_valid), 32'd0);

    // Requester 1: 40 cycles of backpressure, then a 64-byte burst limit.
    req_valid[1] = 1'b1;
    set_byte(1, 8'h42);
    tick();
    chk("b_tag1_byte", 32'(out_byte), 32'h31);
    tick();
    out_ready    = 1'b0;
    req_valid[0] = 1'b1;
    settle();
    for (int i = 0; i < 40; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_byte",  32'(out_byte),  32'h42);
      chk("bp_out_src",   32'(out_src),   32'd1);
      tick();
    end
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    req_valid[0] = 1'b0;
    out_ready    = 1'b1;
    settle();
    chk("bp_resume_ready", 32'(req_ready), 32'b0010);
    for (int i = 1; i <= 63; i++) begin
      tick();
      chk("burst_in_data", 32'(out_valid), 32'd1);
    end
    tick();
    chk("burst_release", 32'(out_valid), 32'd0);
    tick();
    chk("burst_retag_byte", 32'(out_byte), 32'h31);
    tick();
    set_byte(1, 8'h0A);
    tick();
    req_valid = '0;
    settle();
    chk("burst_end_valid", 32'(out_valid), 32'd0);

    // Requester 3 granted, tag held under backpressure, then 16 idle cycles.
    req_valid[3] = 1'b1;
    set_byte(3, 8'h44);
    set_byte(0, 8'h45);
    tick();
    out_ready = 1'b0;
    settle();
    chk("to_tag3_byte", 32'(out_byte), 32'h33);
    tick();
    chk("to_tag3_hold", 32'(out_byte), 32'h33);
    out_ready = 1'b1;
    tick();
    req_valid = 4'b0001;
    settle();
    chk("to_data_ready", 32'(req_ready), 32'b1000);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_still_granted", 32'(req_ready), 32'b1000);
    end
    tick();
    chk("to_released", 32'(req_ready), 32'd0);
    tick();
    chk("to_next_tag", 32'(out_byte), 32'h30);
    tick();
    set_byte(0, 8'h0A);
    tick();
    req_valid = '0;
    settle();

    // All four valid, one-byte lines: round-robin from requester 1.
    for (int i = 0; i < N; i++) set_byte(i, 8'h0A);
    req_valid = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      tick();
      chk("rr_tag_byte", 32'(out_byte), 32'(8'h30 + 8'((g + 1) % N)));
      tick();
      chk("rr_data_src", 32'(out_src), 32'((g + 1) % N));
      if (out_valid && out_ready) xfer_cnt[out_src]++;
      tick();
      chk("rr_bubble", 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < N; i++) chk("rr_share", 32'(xfer_cnt[i]), 32'd2);

    // Reset mid-DATA: outputs fall without a clock edge; requester 0 wins next.
    for (int i = 0; i < N; i++) set_byte(i, 8'h43);
    tick();
    tick();
    chk("rd_in_data", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rd_async_valid", 32'(out_valid), 32'd0);
    chk("rd_async_byte",  32'(out_byte),  32'd0);
    chk("rd_async_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rd_first_src",  32'(out_src),  32'd0);
    chk("rd_first_byte", 32'(out_byte), 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_printer_arbiter.md
BYTE_PRINTER_ARBITER -- requirements
Module: byte_printer_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of byte-stream requesters sharing one printer sink; legal range 2..10.
REQ-002 Parameter MAX_BURST, default 64: maximum data bytes per grant; legal range 1..255.
REQ-003 Parameter IDLE_TIMEOUT, default 16: consecutive stalled cycles before a granted requester loses its grant; legal range 1..255.
REQ-004 Parameter TAG_EN, default 1: when 1, a source tag byte precedes each grant's data.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-007 req_valid  input  N_REQ  per-requester byte valid.
REQ-008 req_byte  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-009 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-010 out_valid  output  1  byte valid to the printer sink.
REQ-011 out_byte  output  8  byte to the printer sink.
REQ-012 out_ready  input  1  sink accept; a transfer occurs when out_valid and out_ready are both 1.
REQ-013 out_src  output  clog2(N_REQ)  index of the granted requester; 0 when out_valid is 0.

Function
REQ-014 FSM states IDLE, TAG and DATA; grant, last_grant, burst_cnt and stall_cnt are registered.
REQ-015 IDLE: out_valid=0, req_ready=0; if any req_valid, latch the winner as grant and go to TAG (TAG_EN=1) or DATA (TAG_EN=0) on the next edge.
REQ-016 Winner selection is round-robin: first asserted req_valid searching upward from last_grant+1, wrapping from N_REQ-1 to 0.
REQ-017 Arbitration latency: first out_valid for a new grant appears exactly one cycle after the IDLE cycle in which req_valid was sampled.
REQ-018 TAG: out_valid=1, out_byte=8'h30+grant, req_ready=0; on transfer go to DATA, otherwise hold the tag byte stable.
REQ-019 DATA: out_valid=req_valid[grant], out_byte=req_byte[grant], req_ready[grant]=out_ready, all other req_ready=0; the path is combinational, adding zero latency.
REQ-020 DATA: on each transfer, burst_cnt increments and stall_cnt clears.
REQ-021 DATA release: a transfer of byte 8'h0A, or a transfer that brings burst_cnt to MAX_BURST, returns the FSM to IDLE, sets last_grant=grant and clears burst_cnt.
REQ-022 DATA stall: each cycle with req_valid[grant]=0 increments stall_cnt; at stall_cnt=IDLE_TIMEOUT, release as in REQ-021 with no transfer.
REQ-023 Cycles with req_valid[grant]=1 and out_ready=0 are sink backpressure: stall_cnt is held and no timeout occurs.
REQ-024 While in TAG or DATA, requests from other requesters are ignored; no preemption.
REQ-025 Release always passes through at least one IDLE cycle (one-cycle bubble), even when other requests are pending.
REQ-026 Simultaneous newline and MAX_BURST on one transfer causes a single release.
REQ-027 Counters saturate and never wrap; burst_cnt and stall_cnt are each 8 bits.
REQ-028 Once asserted, out_valid with a stable out_byte holds until transfer in TAG; in DATA it follows the requester's own valid/ready protocol.

Reset
REQ-029 While reset=0: FSM=IDLE, out_valid=0, out_byte=0, out_src=0, req_ready=0, burst_cnt=0, stall_cnt=0, last_grant=N_REQ-1 (requester 0 wins the first arbitration).
REQ-030 Reset asserted mid-TAG or mid-DATA drops the in-flight grant; out_valid deasserts asynchronously with no partial tag retransmission after release.
REQ-031 The first arbitration may occur on the first posedge clk after reset deasserts.

Verification
REQ-032 Requesters 0 and 2 both valid after reset, sink always ready, streams "A\n" -> sink sees '0','A',0x0A,'2',... in that order, with one IDLE bubble between grants.
REQ-033 Requester 1 streams 70 bytes with no newline, MAX_BURST=64, TAG_EN=1 -> sink sees '1' plus 64 bytes, a bubble, then '1' plus the remaining 6 bytes.
REQ-034 Granted requester 3 drops valid for 16 cycles while requester 0 waits -> release on cycle 16; next tag is '0'.
REQ-035 out_ready held 0 for 40 cycles during DATA with req_valid[grant]=1 -> no timeout, out_byte stable, grant retained.
REQ-036 All 4 requesters continuously valid, with newline-terminated 1-byte lines -> grant order 0,1,2,3,0,... and each requester gets equal transfers within 1.
REQ-037 Reset pulsed low mid-DATA -> out_valid=0 within the reset cycle with no clock edge; after release, requester 0 wins the first arbitration.
